// File: rtl/projectile_pool.sv
// projectile_pool: NUM_PROJ projectile slots with frame-stepped motion,
// off-screen retirement, target hit detection and shot arbitration.
// Build option: define PROJ_HIT_COUNT_EN to implement the saturating 8-bit
// hit_count register; when undefined, hit_count is tied to zero.
module projectile_pool #(
  parameter int NUM_PROJ        = 4,
  parameter int X_STEP          = 4,
  parameter int PROJ_SIZE       = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SCREEN_W        = 640
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                fire,
  input  logic                dir,
  input  logic [9:0]          Shooter_X,
  input  logic [9:0]          Shooter_Y,
  input  logic [9:0]          Target_X,
  input  logic [9:0]          Target_Y,
  input  logic [9:0]          Target_X_Size,
  input  logic [9:0]          Target_Y_Size,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic                is_proj,
  output logic                hit,
  output logic                fire_ack,
  output logic                fire_drop,
  output logic [NUM_PROJ-1:0] active_mask,
  output logic [7:0]          hit_count
);

  // All geometry is done in 11 bits so sums never wrap.
  localparam logic [10:0] STEP_W  = 11'(X_STEP);
  localparam logic [10:0] SIZE_W  = 11'(PROJ_SIZE);
  localparam logic [10:0] SCRN_W  = 11'(SCREEN_W);
  localparam logic [7:0]  CD_INIT = 8'(COOLDOWN_FRAMES);

  logic       frame_s1_reg, frame_s2_reg, frame_s2_d_reg, frame_tick_reg;
  logic       fire_d_reg, pending_reg;
  logic [7:0] cooldown_reg;
  logic       hit_reg, fire_ack_reg, fire_drop_reg;

  logic [NUM_PROJ-1:0] slot_hit, slot_retire, slot_pix, spawn_sel;
  logic                fire_rise, can_serve, any_free;
  logic [10:0]         tgt_x0, tgt_x1, tgt_y0, tgt_y1;
  logic [10:0]         draw_x, draw_y;

  assign tgt_x0 = {1'b0, Target_X};
  assign tgt_x1 = {1'b0, Target_X} + {1'b0, Target_X_Size};
  assign tgt_y0 = {1'b0, Target_Y};
  assign tgt_y1 = {1'b0, Target_Y} + {1'b0, Target_Y_Size};
  assign draw_x = {1'b0, DrawX};
  assign draw_y = {1'b0, DrawY};

  assign fire_rise = fire & ~fire_d_reg;
  assign can_serve = frame_tick_reg & pending_reg & (cooldown_reg == 8'd0);

  for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_slot
    logic        active_reg, dir_reg;
    logic [9:0]  x_reg, y_reg;
    logic [10:0] x_cur, y_cur, x_mov;
    logic        off_edge, overlap;

    assign x_cur    = {1'b0, x_reg};
    assign y_cur    = {1'b0, y_reg};
    // Edge test uses the pre-move position so the shot retires in place.
    assign off_edge = dir_reg ? (x_cur < STEP_W) : (x_cur + STEP_W + SIZE_W > SCRN_W);
    assign x_mov    = dir_reg ? (x_cur - STEP_W) : (x_cur + STEP_W);
    assign overlap  = (x_mov + SIZE_W > tgt_x0) && (x_mov < tgt_x1) &&
                      (y_cur + SIZE_W > tgt_y0) && (y_cur < tgt_y1);

    assign slot_hit[gi]    = active_reg && !off_edge && overlap;
    assign slot_retire[gi] = active_reg && (off_edge || overlap);
    assign slot_pix[gi]    = active_reg &&
                             (draw_x >= x_cur) && (draw_x < x_cur + SIZE_W) &&
                             (draw_y >= y_cur) && (draw_y < y_cur + SIZE_W);
    assign active_mask[gi] = active_reg;

    // Slot state: spawn into a free slot, otherwise retire or step once per frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        active_reg <= 1'b0;
        dir_reg    <= 1'b0;
        x_reg      <= 10'd0;
        y_reg      <= 10'd0;
      end else if (frame_tick_reg) begin
        if (spawn_sel[gi]) begin
          active_reg <= 1'b1;
          dir_reg    <= dir;
          x_reg      <= Shooter_X;
          y_reg      <= Shooter_Y;
        end else if (slot_retire[gi]) begin
          active_reg <= 1'b0;
        end else if (active_reg) begin
          x_reg <= x_mov[9:0];
        end
      end
    end
  end

  // Pick the lowest-index slot that was free before this tick.
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (!active_mask[i] && !any_free) begin
        spawn_sel[i] = can_serve;
        any_free     = 1'b1;
      end
    end
  end

  // Frame synchroniser, fire edge capture, shot arbitration and pulse outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_s1_reg   <= 1'b0;
      frame_s2_reg   <= 1'b0;
      frame_s2_d_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
      fire_d_reg     <= 1'b0;
      pending_reg    <= 1'b0;
      cooldown_reg   <= 8'd0;
      hit_reg        <= 1'b0;
      fire_ack_reg   <= 1'b0;
      fire_drop_reg  <= 1'b0;
    end else begin
      frame_s1_reg   <= frame_clk;
      frame_s2_reg   <= frame_s1_reg;
      frame_s2_d_reg <= frame_s2_reg;
      frame_tick_reg <= frame_s2_reg & ~frame_s2_d_reg;
      fire_d_reg     <= fire;
      hit_reg        <= 1'b0;
      fire_ack_reg   <= 1'b0;
      fire_drop_reg  <= 1'b0;
      if (frame_tick_reg) begin
        hit_reg <= |slot_hit;
        if (pending_reg && cooldown_reg == 8'd0) begin
          // A request arriving on the servicing tick waits for the next one.
          pending_reg <= fire_rise;
          if (any_free) begin
            fire_ack_reg <= 1'b1;
            cooldown_reg <= CD_INIT;
          end else begin
            fire_drop_reg <= 1'b1;
          end
        end else begin
          pending_reg <= pending_reg | fire_rise;
          if (cooldown_reg != 8'd0) cooldown_reg <= cooldown_reg - 8'd1;
        end
      end else begin
        pending_reg <= pending_reg | fire_rise;
      end
    end
  end

  assign is_proj   = |slot_pix;
  assign hit       = hit_reg;
  assign fire_ack  = fire_ack_reg;
  assign fire_drop = fire_drop_reg;

`ifdef PROJ_HIT_COUNT_EN
  logic [3:0] hit_num;
  logic [8:0] hit_count_sum;
  logic [7:0] hit_count_reg;

  // Number of slots that struck the target on this tick.
  always_comb begin
    hit_num = 4'd0;
    for (int i = 0; i < NUM_PROJ; i++) hit_num = hit_num + 4'(slot_hit[i]);
  end

  assign hit_count_sum = {1'b0, hit_count_reg} + 9'(hit_num);

  // Cumulative hit counter, saturating at 255.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_count_reg <= 8'd0;
    end else if (frame_tick_reg) begin
      hit_count_reg <= hit_count_sum[8] ? 8'hFF : hit_count_sum[7:0];
    end
  end

  assign hit_count = hit_count_reg;
`else
  assign hit_count = 8'd0;
`endif

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: dut_a uses COOLDOWN_FRAMES=0,
// dut_b keeps the default cooldown of 8 frames; both share all inputs.
module tb_projectile_pool;

`ifdef PROJ_HIT_COUNT_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  always #10 Clk = ~Clk;

  logic       Reset_n, frame_clk, fire, dir;
  logic [9:0] Shooter_X, Shooter_Y, Target_X, Target_Y;
  logic [9:0] Target_X_Size, Target_Y_Size, DrawX, DrawY;

  logic       is_proj_a, hit_a, fire_ack_a, fire_drop_a;
  logic [3:0] active_mask_a;
  logic [7:0] hit_count_a;
  logic       is_proj_b, hit_b, fire_ack_b, fire_drop_b;
  logic [3:0] active_mask_b;
  logic [7:0] hit_count_b;

  projectile_pool #(.COOLDOWN_FRAMES(0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire), .dir(dir),
    .Shooter_X(Shooter_X), .Shooter_Y(Shooter_Y), .Target_X(Target_X), .Target_Y(Target_Y),
    .Target_X_Size(Target_X_Size), .Target_Y_Size(Target_Y_Size), .DrawX(DrawX), .DrawY(DrawY),
    .is_proj(is_proj_a), .hit(hit_a), .fire_ack(fire_ack_a), .fire_drop(fire_drop_a),
    .active_mask(active_mask_a), .hit_count(hit_count_a)
  );

  projectile_pool dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire), .dir(dir),
    .Shooter_X(Shooter_X), .Shooter_Y(Shooter_Y), .Target_X(Target_X), .Target_Y(Target_Y),
    .Target_X_Size(Target_X_Size), .Target_Y_Size(Target_Y_Size), .DrawX(DrawX), .DrawY(DrawY),
    .is_proj(is_proj_b), .hit(hit_b), .fire_ack(fire_ack_b), .fire_drop(fire_drop_b),
    .active_mask(active_mask_b), .hit_count(hit_count_b)
  );

  int errors = 0;
  int checks = 0;
  int ack_a_cnt = 0, drop_a_cnt = 0, hit_a_cnt = 0, ack_b_cnt = 0, drop_b_cnt = 0;
  int wide_cnt = 0;
  logic ack_a_q = 1'b0, drop_a_q = 1'b0, hit_a_q = 1'b0, ack_b_q = 1'b0;

  // Pulse counters, sampled on the falling edge; also flags any pulse wider than one Clk.
  always @(negedge Clk) begin
    if (fire_ack_a)  ack_a_cnt++;
    if (fire_drop_a) drop_a_cnt++;
    if (hit_a)       hit_a_cnt++;
    if (fire_ack_b)  ack_b_cnt++;
    if (fire_drop_b) drop_b_cnt++;
    if ((fire_ack_a && ack_a_q) || (fire_drop_a && drop_a_q) ||
        (hit_a && hit_a_q) || (fire_ack_b && ack_b_q)) wide_cnt++;
    ack_a_q  = fire_ack_a;
    drop_a_q = fire_drop_a;
    hit_a_q  = hit_a;
    ack_b_q  = fire_ack_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: frame_clk high for 4 Clk then low for 4 Clk; the tick lands mid-high.
  task automatic do_frame();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    @(negedge Clk);
    fire = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  function automatic logic [31:0] hc(input int v);
    return HC_EN ? 32'(v) : 32'd0;
  endfunction

  int base_ack, base_drop, base_hit, base_ack_b, base_drop_b, first_tick;

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; dir = 1'b0;
    Shooter_X = 10'd0; Shooter_Y = 10'd0;
    Target_X = 10'd360; Target_Y = 10'd355; Target_X_Size = 10'd42; Target_Y_Size = 10'd64;
    DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(negedge Clk);

    // Reset state
    check("rst_mask",  32'(active_mask_a), 32'd0);
    check("rst_isproj", 32'(is_proj_a), 32'd0);
    check("rst_hit",   32'(hit_a), 32'd0);
    check("rst_ack",   32'(fire_ack_a), 32'd0);
    check("rst_drop",  32'(fire_drop_a), 32'd0);
    check("rst_hc",    32'(hit_count_a), 32'd0);
    check("rst_mask_b", 32'(active_mask_b), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Spawn and move: 281 -> 285 -> 289
    base_ack = ack_a_cnt;
    Shooter_X = 10'd281; Shooter_Y = 10'd387; dir = 1'b0;
    pulse_fire(); do_frame();
    check("spawn_ack", 32'(ack_a_cnt - base_ack), 32'd1);
    check("spawn_mask", 32'(active_mask_a), 32'd1);
    DrawY = 10'd388; DrawX = 10'd281; #1;
    check("x281_in", 32'(is_proj_a), 32'd1);
    DrawX = 10'd280; #1;
    check("x281_left", 32'(is_proj_a), 32'd0);
    do_frame();
    DrawX = 10'd285; #1;
    check("x285_in", 32'(is_proj_a), 32'd1);
    DrawX = 10'd284; #1;
    check("x285_left", 32'(is_proj_a), 32'd0);
    do_frame();
    DrawX = 10'd290; #1;
    check("x289_d290", 32'(is_proj_a), 32'd1);
    DrawX = 10'd293; #1;
    check("x289_d293", 32'(is_proj_a), 32'd0);
    DrawX = 10'd289; DrawY = 10'd391; #1;
    check("x289_y391", 32'(is_proj_a), 32'd0);
    check("spawn_noack_more", 32'(ack_a_cnt - base_ack), 32'd1);

    // Hit: from X=340, overlap when X reaches 360
    do_reset();
    base_hit = hit_a_cnt;
    Shooter_X = 10'd340; Shooter_Y = 10'd387;
    pulse_fire(); do_frame();
    repeat (4) do_frame();
    DrawX = 10'd356; DrawY = 10'd388; #1;
    check("hit_pre_x356", 32'(is_proj_a), 32'd1);
    check("hit_pre_none", 32'(hit_a_cnt - base_hit), 32'd0);
    do_frame();
    check("hit_pulse", 32'(hit_a_cnt - base_hit), 32'd1);
    check("hit_retire", 32'(active_mask_a), 32'd0);
    check("hit_count1", 32'(hit_count_a), hc(1));

    // Drop: 5 shots one frame apart with no cooldown
    do_reset();
    base_ack = ack_a_cnt; base_drop = drop_a_cnt;
    Shooter_X = 10'd100; Shooter_Y = 10'd100;
    repeat (5) begin pulse_fire(); do_frame(); end
    check("drop_acks", 32'(ack_a_cnt - base_ack), 32'd4);
    check("drop_drops", 32'(drop_a_cnt - base_drop), 32'd1);
    check("drop_mask", 32'(active_mask_a), 32'hF);

    // Async reset with 3 active slots and a pending request
    do_reset();
    repeat (3) begin pulse_fire(); do_frame(); end
    check("ar_mask3", 32'(active_mask_a), 32'h7);
    pulse_fire();
    DrawX = 10'd101; DrawY = 10'd101; #1;
    check("ar_isproj_pre", 32'(is_proj_a), 32'd1);
    base_ack = ack_a_cnt;
    @(posedge Clk); #3;
    Reset_n = 1'b0; #1;
    check("ar_mask0", 32'(active_mask_a), 32'd0);
    check("ar_isproj0", 32'(is_proj_a), 32'd0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    do_frame(); do_frame();
    check("ar_noack", 32'(ack_a_cnt - base_ack), 32'd0);
    check("ar_mask_after", 32'(active_mask_a), 32'd0);

    // Cooldown (dut_b, 8 frames): second request held until cooldown expires
    do_reset();
    base_ack_b = ack_b_cnt; base_drop_b = drop_b_cnt; base_ack = ack_a_cnt;
    pulse_fire(); do_frame();
    check("cd_first_ack", 32'(ack_b_cnt - base_ack_b), 32'd1);
    do_frame();
    pulse_fire();
    first_tick = 0;
    for (int k = 2; k <= 10; k++) begin
      do_frame();
      if (first_tick == 0 && (ack_b_cnt - base_ack_b) == 2) first_tick = k;
    end
    check("cd_ack_frame_8or9", 32'(first_tick == 8 || first_tick == 9), 32'd1);
    check("cd_acks_b", 32'(ack_b_cnt - base_ack_b), 32'd2);
    check("cd_drops_b", 32'(drop_b_cnt - base_drop_b), 32'd0);
    check("cd_acks_a_nocd", 32'(ack_a_cnt - base_ack), 32'd2);

    // Edge retire, leftward: 6 -> 2 -> retired
    do_reset();
    base_hit = hit_a_cnt;
    dir = 1'b1; Shooter_X = 10'd6; Shooter_Y = 10'd100;
    pulse_fire(); do_frame();
    DrawX = 10'd6; DrawY = 10'd101; #1;
    check("left_x6", 32'(is_proj_a), 32'd1);
    do_frame();
    DrawX = 10'd2; #1;
    check("left_x2", 32'(is_proj_a), 32'd1);
    DrawX = 10'd6; #1;
    check("left_x2_not6", 32'(is_proj_a), 32'd0);
    do_frame();
    check("left_retire", 32'(active_mask_a), 32'd0);
    check("left_nohit", 32'(hit_a_cnt - base_hit), 32'd0);

    // Edge retire, rightward: 633 + 4 + 4 > 640 retires on the first tick
    dir = 1'b0; Shooter_X = 10'd633;
    pulse_fire(); do_frame();
    check("right_spawn", 32'(active_mask_a), 32'd1);
    DrawX = 10'd636; #1;
    check("right_x633", 32'(is_proj_a), 32'd1);
    do_frame();
    check("right_retire", 32'(active_mask_a), 32'd0);
    check("right_nohit", 32'(hit_a_cnt - base_hit), 32'd0);

    // Simultaneous: two slots reach X=360 on the same tick
    do_reset();
    base_hit = hit_a_cnt;
    Shooter_X = 10'd352; Shooter_Y = 10'd387;
    pulse_fire(); do_frame();
    Shooter_X = 10'd356; Shooter_Y = 10'd390;
    pulse_fire(); do_frame();
    check("sim_mask", 32'(active_mask_a), 32'h3);
    check("sim_nohit_yet", 32'(hit_a_cnt - base_hit), 32'd0);
    do_frame();
    check("sim_one_pulse", 32'(hit_a_cnt - base_hit), 32'd1);
    check("sim_hc2", 32'(hit_count_a), hc(2));
    check("sim_mask0", 32'(active_mask_a), 32'd0);

    // Saturation: build to 254, then a double hit saturates at 255
    base_drop = drop_a_cnt;
    Shooter_X = 10'd356; Shooter_Y = 10'd387;
    repeat (252) begin pulse_fire(); do_frame(); end
    do_frame();
    check("sat_drops", 32'(drop_a_cnt - base_drop), 32'd0);
    check("sat_hc254", 32'(hit_count_a), hc(254));
    Shooter_X = 10'd352; Shooter_Y = 10'd387;
    pulse_fire(); do_frame();
    Shooter_X = 10'd356; Shooter_Y = 10'd390;
    pulse_fire(); do_frame();
    base_hit = hit_a_cnt;
    do_frame();
    check("sat_pulse", 32'(hit_a_cnt - base_hit), 32'd1);
    check("sat_hc255", 32'(hit_count_a), hc(255));

    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
